// File: rtl/serial_frame_sipo_if.sv
// Serial-in / parallel-out frame bus: serial bit stream in, decoded words and status out.
interface serial_frame_sipo_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             sin;
    logic             sin_vld;
    logic [WIDTH-1:0] word_out;
    logic             word_vld;
    logic             locked;
    logic             sync_err;

    // Upstream / bench side: drives the serial stream, observes the decoder.
    modport master (
        output sin,
        output sin_vld,
        input  word_out,
        input  word_vld,
        input  locked,
        input  sync_err
    );

    // Decoder side.
    modport slave (
        input  sin,
        input  sin_vld,
        output word_out,
        output word_vld,
        output locked,
        output sync_err
    );
endinterface

// File: rtl/serial_frame_sipo.sv
// Frame-aligning deserializer: hunts for a sync pattern, unpacks NUM_WORDS MSB-first words,
// then re-checks the sync pattern before every following frame.
module serial_frame_sipo #(
    parameter int unsigned         WIDTH     = 8,
    parameter int unsigned         NUM_WORDS = 2,
    parameter int unsigned         SYNC_LEN  = 8,
    parameter logic [SYNC_LEN-1:0] SYNC_PAT  = SYNC_LEN'(8'hA5)
) (
    input logic                clk,
    input logic                rst_n,
    serial_frame_sipo_if.slave bus
);

    localparam int unsigned CntMax = (WIDTH > SYNC_LEN) ? WIDTH : SYNC_LEN;
    localparam int unsigned BcW    = $clog2(CntMax);
    localparam int unsigned WcW    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [BcW-1:0] BitLastWord = BcW'(WIDTH - 1);
    localparam logic [BcW-1:0] BitLastSync = BcW'(SYNC_LEN - 1);
    localparam logic [WcW-1:0] WordLast    = WcW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        StHunt,
        StData,
        StCheck
    } state_e;

    state_e              state_q, state_d;
    logic [SYNC_LEN-1:0] hist_q, hist_d;
    logic [WIDTH-1:0]    shreg_q, shreg_d;
    logic [BcW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WcW-1:0]      word_cnt_q, word_cnt_d;
    logic [WIDTH-1:0]    word_out_q, word_out_d;
    logic                word_vld_q, word_vld_d;
    logic                locked_q, locked_d;
    logic                sync_err_q, sync_err_d;

    logic [SYNC_LEN-1:0] hist_shift;
    logic [WIDTH-1:0]    shreg_shift;

    assign hist_shift  = {hist_q[SYNC_LEN-2:0], bus.sin};
    assign shreg_shift = {shreg_q[WIDTH-2:0], bus.sin};

    // Next-state: every register holds on a stalled bit; only the pulses self-clear.
    always_comb begin
        state_d    = state_q;
        hist_d     = hist_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        word_out_d = word_out_q;
        word_vld_d = 1'b0;
        sync_err_d = 1'b0;

        if (bus.sin_vld) begin
            unique case (state_q)
                StHunt: begin
                    // Sliding match, so the stream may lock at any bit offset.
                    hist_d = hist_shift;
                    if (hist_shift == SYNC_PAT) begin
                        state_d    = StData;
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                    end
                end
                StData: begin
                    shreg_d = shreg_shift;
                    if (bit_cnt_q == BitLastWord) begin
                        word_out_d = shreg_shift;
                        word_vld_d = 1'b1;
                        bit_cnt_d  = '0;
                        if (word_cnt_q == WordLast) begin
                            state_d    = StCheck;
                            word_cnt_d = '0;
                            hist_d     = '0;
                        end else begin
                            word_cnt_d = word_cnt_q + WcW'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BcW'(1);
                    end
                end
                StCheck: begin
                    hist_d = hist_shift;
                    if (bit_cnt_q == BitLastSync) begin
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                        if (hist_shift == SYNC_PAT) begin
                            state_d = StData;
                        end else begin
                            // Failed sync bits are discarded; hunting restarts from scratch.
                            state_d    = StHunt;
                            hist_d     = '0;
                            sync_err_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BcW'(1);
                    end
                end
                default: begin
                    state_d = StHunt;
                end
            endcase
        end

        locked_d = (state_d != StHunt);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StHunt;
            hist_q     <= '0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            word_out_q <= '0;
            word_vld_q <= 1'b0;
            locked_q   <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hist_q     <= hist_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            word_out_q <= word_out_d;
            word_vld_q <= word_vld_d;
            locked_q   <= locked_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign bus.word_out = word_out_q;
    assign bus.word_vld = word_vld_q;
    assign bus.locked   = locked_q;
    assign bus.sync_err = sync_err_q;

endmodule
